matmul_sequencer: RTL

Controller that sequences the 4x4 matrix multiply after both operand memories are loaded. Once `start` is asserted, it reads operand A from Feature Memory and operand W from Weight Memory, accumulates dot products in a local MAC, and writes the 16 results back into Feature Memory at word 16 onward. It sits between the memory loader's storage arrays and the top-level `startSignal`, and is the sole master of the memory read ports and the result write port during computation.

---
 rtl/matmul_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences an N x N matrix multiply O = A * W.
// A is read from Feature Memory (row-major at word 0), W from Weight Memory (row-major
// at word 0). Results go back into Feature Memory from word RES_BASE onward, i outer, j inner.
// Each element takes N READ cycles, one DRAIN cycle and one WRITE cycle.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            level request, sampled only in IDLE; a held level never retriggers
//   fmem_raddr/rdata Feature Memory read port (data one cycle after address)
//   wmem_raddr/rdata Weight Memory read port (data one cycle after address)
//   fmem_we/waddr/wdata registered result write port, one strobe per element
//   busy             high in READ, DRAIN and WRITE
//   done             one-cycle completion pulse
//
// Build option: define MATMUL_SAT_EN to saturate results to 2^DW-1 instead of
// truncating them modulo 2^DW.

module matmul_sequencer #(
  parameter int unsigned N        = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned FAW      = 6,
  parameter int unsigned WAW      = 4,
  parameter int unsigned RES_BASE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [FAW-1:0] fmem_raddr,
  input  logic [DW-1:0]  fmem_rdata,
  output logic [WAW-1:0] wmem_raddr,
  input  logic [DW-1:0]  wmem_rdata,
  output logic           fmem_we,
  output logic [FAW-1:0] fmem_waddr,
  output logic [DW-1:0]  fmem_wdata,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  // Wide enough to sum N full-scale products without overflow.
  localparam int unsigned AW = 2 * DW + $clog2(N);
  localparam logic [CW-1:0] Last = CW'(N - 1);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone, StHold} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   i_q, j_q, k_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic            rvalid_q;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   res;
  logic            last_elem;

  assign last_elem = (i_q == Last) && (j_q == Last);

  // Next state and decoded outputs.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    fmem_raddr = '0;
    wmem_raddr = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StRead;
      StRead: begin
        busy       = 1'b1;
        fmem_raddr = FAW'(32'(i_q) * N + 32'(k_q));
        wmem_raddr = WAW'(32'(k_q) * N + 32'(j_q));
        if (k_q == Last) state_d = StDrain;
      end
      StDrain: begin
        busy    = 1'b1;
        state_d = StWrite;
      end
      StWrite: begin
        busy    = 1'b1;
        state_d = last_elem ? StDone : StRead;
      end
      StDone: begin
        done    = 1'b1;
        state_d = start ? StHold : StIdle;
      end
      StHold: if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read data lags the address by a cycle, so the product is folded in one cycle later.
  always_comb begin
    prod  = (2 * DW)'(fmem_rdata) * (2 * DW)'(wmem_rdata);
    acc_d = rvalid_q ? acc_q + AW'(prod) : acc_q;
`ifdef MATMUL_SAT_EN
    res   = (acc_d > AW'({DW{1'b1}})) ? {DW{1'b1}} : acc_d[DW-1:0];
`else
    res   = acc_d[DW-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      rvalid_q   <= 1'b0;
      fmem_we    <= 1'b0;
      fmem_waddr <= '0;
      fmem_wdata <= '0;
    end else begin
      rvalid_q <= (state_q == StRead);
      // Result is captured on entry to WRITE, using the accumulator including the last product.
      fmem_we  <= (state_d == StWrite);
      if (state_d == StWrite) begin
        fmem_waddr <= FAW'(RES_BASE + 32'(i_q) * N + 32'(j_q));
        fmem_wdata <= res;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        StRead: begin
          k_q   <= (k_q == Last) ? '0 : k_q + 1'b1;
          acc_q <= acc_d;
        end
        StDrain: acc_q <= acc_d;
        StWrite: begin
          acc_q <= '0;
          if (last_elem) begin
            i_q <= '0;
            j_q <= '0;
          end else if (j_q == Last) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
